// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file with an integrated pending-write scoreboard for a pipelined
// MIPS datapath. Two combinational read ports see the incoming write through
// a bypass. One rising-edge write port stores data. A pending bit per register
// tracks issued-but-not-written producers, so decode can detect RAW hazards.
//
// Ports:
//   clk, reset             clock; asynchronous active-high clear of all state
//   rd_addr1/2             read addresses
//   rd_data1/2             read data, combinational, with write bypass
//   rd_busy1/2             addressed register still awaits its producer
//   wr_en/wr_addr/wr_data  write port; also clears the pending bit
//   rsv_en/rsv_addr        reserve: mark a register pending at the edge
//   rsv_conflict           reservation target is already pending (WAW)
//   flush                  clear every pending bit at the edge
//   pending_cnt            number of pending registers
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_conflict,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  // The whole array clears on reset and is read asynchronously, so it is
  // built from flops rather than a RAM primitive.
  logic [DATA_W-1:0] regArray [DEPTH];
  logic [DEPTH-1:0]  pendingReg;
  logic [DEPTH-1:0]  pendingNext;
  logic [ADDR_W:0]   pendingCntReg;
  logic [ADDR_W:0]   pendingCntNext;

  logic wrValid;
  logic rsvValid;
  logic becomesSet;
  logic becomesClr;

  // With a hardwired zero register, writes and reservations to r0 are dropped
  // here, so entry 0 stays zero and its pending bit never sets.
  assign wrValid  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
  assign rsvValid = rsv_en && !(ZERO_REG && (rsv_addr == '0));

  // Read ports: both share the same bypass and busy logic.
  logic [ADDR_W-1:0] rdAddr [2];
  logic [DATA_W-1:0] rdData [2];
  logic              rdBusy [2];

  assign rdAddr[0] = rd_addr1;
  assign rdAddr[1] = rd_addr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gRead
      logic hit;
      logic zeroAddr;
      assign zeroAddr   = ZERO_REG && (rdAddr[gi] == '0);
      assign hit        = wr_en && (wr_addr == rdAddr[gi]);
      assign rdData[gi] = zeroAddr ? '0 : (hit ? wr_data : regArray[rdAddr[gi]]);
      // A write in this cycle satisfies the hazard even though the stored
      // bit only clears at the edge.
      assign rdBusy[gi] = pendingReg[rdAddr[gi]] & ~hit;
    end
  endgenerate

  assign rd_data1 = rdData[0];
  assign rd_data2 = rdData[1];
  assign rd_busy1 = rdBusy[0];
  assign rd_busy2 = rdBusy[1];

  assign rsv_conflict = rsv_en & pendingReg[rsv_addr];
  assign pending_cnt  = pendingCntReg;

  // Flush beats everything. Otherwise a reservation is applied after the
  // write clear, so on a shared address the new producer keeps the bit set.
  always_comb begin
    pendingNext = pendingReg;
    if (flush) begin
      pendingNext = '0;
    end else begin
      if (wrValid)  pendingNext[wr_addr]  = 1'b0;
      if (rsvValid) pendingNext[rsv_addr] = 1'b1;
    end
  end

  // Incremental popcount: at most one bit sets and one clears per cycle.
  assign becomesSet = rsvValid && !pendingReg[rsv_addr];
  assign becomesClr = wrValid && pendingReg[wr_addr] &&
                      !(rsvValid && (rsv_addr == wr_addr));

  always_comb begin
    pendingCntNext = pendingCntReg;
    if (flush) begin
      pendingCntNext = '0;
    end else begin
      pendingCntNext = pendingCntReg + (ADDR_W+1)'(becomesSet)
                                     - (ADDR_W+1)'(becomesClr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendingReg    <= '0;
      pendingCntReg <= '0;
    end else begin
      pendingReg    <= pendingNext;
      pendingCntReg <= pendingCntNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regArray[i] <= '0;
    end else if (wrValid) begin
      regArray[wr_addr] <= wr_data;
    end
  end

endmodule
